// File: rtl/ceespu_mem_model.sv
// Word-addressed memory responder for the ceespu core: pipelined imem/dmem reads,
// byte-enable stores, bench preload, tohost completion capture, OOB flag and cycle counter.
module ceespu_mem_model #(
  parameter int unsigned            ADDR_WIDTH   = 16,
  parameter int unsigned            DEPTH_LOG2   = 10,
  parameter int unsigned            READ_LATENCY = 1,
  parameter logic [ADDR_WIDTH-1:0]  TOHOST_ADDR  = 16'hFFFC
) (
  input  logic                  I_clk,
  input  logic                  I_rst_n,
  input  logic [ADDR_WIDTH-1:0] I_imemAddress,
  output logic [31:0]           O_imemData,
  output logic                  O_imemValid,
  input  logic [ADDR_WIDTH-1:0] I_dmemAddress,
  input  logic [31:0]           I_dmemWData,
  input  logic                  I_dmemE,
  input  logic [3:0]            I_dmemWe,
  output logic [31:0]           O_dmemData,
  output logic                  O_dmemValid,
  input  logic                  I_loadE,
  input  logic [DEPTH_LOG2-1:0] I_loadAddr,
  input  logic [31:0]           I_loadData,
  output logic                  O_done,
  output logic [31:0]           O_doneValue,
  output logic                  O_oob,
  output logic [31:0]           O_cycles
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned L     = READ_LATENCY;

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("ceespu_mem_model: READ_LATENCY must be in 1..4");
  end
  if (ADDR_WIDTH <= DEPTH_LOG2 + 2) begin : g_bad_width
    $error("ceespu_mem_model: ADDR_WIDTH must exceed DEPTH_LOG2+2");
  end

  // Any address bit above the word index makes an access out of range; tohost is exempt.
  function automatic logic is_oob(input logic [ADDR_WIDTH-1:0] a);
    return ((a >> (DEPTH_LOG2 + 2)) != '0) && (a != TOHOST_ADDR);
  endfunction

  logic [31:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] im_idx, dm_idx;
  logic                  im_oob, dm_oob, dm_load, dm_store, tohost_store, st_wr, preload_wins;
  logic [31:0]           im_rd, dm_rd;

  assign im_idx       = I_imemAddress[DEPTH_LOG2+1:2];
  assign dm_idx       = I_dmemAddress[DEPTH_LOG2+1:2];
  assign im_oob       = is_oob(I_imemAddress);
  assign dm_oob       = I_dmemE && is_oob(I_dmemAddress);
  assign dm_load      = I_dmemE && (I_dmemWe == 4'b0000);
  assign dm_store     = I_dmemE && (I_dmemWe != 4'b0000);
  assign tohost_store = dm_store && (I_dmemAddress == TOHOST_ADDR);
  assign st_wr        = dm_store && !dm_oob && !tohost_store;
  assign preload_wins = I_loadE && (I_loadAddr == dm_idx);

  // Reads sample the array before this edge's writes land: read-before-write on collision.
  assign im_rd = im_oob ? 32'h0 : mem_q[im_idx];
  assign dm_rd = dm_oob ? 32'h0 : mem_q[dm_idx];

  always_ff @(posedge I_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (st_wr && !preload_wins && I_dmemWe[b]) begin
        mem_q[dm_idx][8*b +: 8] <= I_dmemWData[8*b +: 8];
      end
    end
    if (I_loadE) begin
      mem_q[I_loadAddr] <= I_loadData;
    end
  end

  // Handshake: a read result is presented for exactly one cycle with its valid high,
  // L cycles after the address edge; there is no back-pressure (no ready).
  logic [L-1:0][31:0] im_data_q, im_data_d, dm_data_q, dm_data_d;
  logic [L-1:0]       im_vld_q, im_vld_d, dm_vld_q, dm_vld_d;
  logic [L-1:0][31:0] im_chain, dm_chain;
  logic [L-1:0]       im_vchain, dm_vchain;

  always_comb begin
    im_chain     = '0;
    dm_chain     = '0;
    im_vchain    = '0;
    dm_vchain    = '0;
    im_chain[0]  = im_rd;
    dm_chain[0]  = dm_rd;
    im_vchain[0] = 1'b1;
    dm_vchain[0] = dm_load;
    for (int i = 0; i + 1 < L; i++) begin
      im_chain[i+1]  = im_data_q[i];
      dm_chain[i+1]  = dm_data_q[i];
      im_vchain[i+1] = im_vld_q[i];
      dm_vchain[i+1] = dm_vld_q[i];
    end
    im_data_d = '0;
    dm_data_d = '0;
    im_vld_d  = '0;
    dm_vld_d  = '0;
    for (int i = 0; i < L; i++) begin
      im_data_d[i] = im_chain[i];
      im_vld_d[i]  = im_vchain[i];
      dm_vld_d[i]  = dm_vchain[i];
      // Load data only advances with a valid load, so the output holds its last value.
      dm_data_d[i] = dm_vchain[i] ? dm_chain[i] : dm_data_q[i];
    end
  end

  logic        done_q, done_d, oob_q, oob_d;
  logic [31:0] done_value_q, done_value_d, cycles_q, cycles_d;

  always_comb begin
    done_d       = done_q | tohost_store;
    done_value_d = (tohost_store && !done_q) ? I_dmemWData : done_value_q;
    oob_d        = oob_q | im_oob | dm_oob;
    cycles_d     = (done_q || tohost_store || (cycles_q == 32'hFFFF_FFFF)) ? cycles_q
                                                                         : cycles_q + 32'd1;
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      im_data_q    <= '0;
      im_vld_q     <= '0;
      dm_data_q    <= '0;
      dm_vld_q     <= '0;
      done_q       <= 1'b0;
      done_value_q <= '0;
      oob_q        <= 1'b0;
      cycles_q     <= '0;
    end else begin
      im_data_q    <= im_data_d;
      im_vld_q     <= im_vld_d;
      dm_data_q    <= dm_data_d;
      dm_vld_q     <= dm_vld_d;
      done_q       <= done_d;
      done_value_q <= done_value_d;
      oob_q        <= oob_d;
      cycles_q     <= cycles_d;
    end
  end

  assign O_imemData  = im_data_q[L-1];
  assign O_imemValid = im_vld_q[L-1];
  assign O_dmemData  = dm_data_q[L-1];
  assign O_dmemValid = dm_vld_q[L-1];
  assign O_done      = done_q;
  assign O_doneValue = done_value_q;
  assign O_oob       = oob_q;
  assign O_cycles    = cycles_q;
endmodule

// File: tb/tb_ceespu_mem_model.sv
// Directed bench for ceespu_mem_model with READ_LATENCY=3: latency, byte enables,
// collisions, preload priority, out-of-range, mid-read reset and tohost capture.
module tb_ceespu_mem_model;
  localparam int AW = 16;
  localparam int DL = 10;
  localparam int RL = 3;

  logic          clk, rst_n;
  logic [AW-1:0] imem_addr, dmem_addr;
  logic [31:0]   imem_data, dmem_data, dmem_wdata, load_data, done_value, cycles;
  logic          imem_valid, dmem_valid, dmem_e, load_e, done, oob;
  logic [3:0]    dmem_we;
  logic [DL-1:0] load_addr;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned rel_cycles = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_w;
  logic [31:0] init_words [4] = '{32'h42a04f06, 32'h4280fffe, 32'h26b5a000, 32'hd012a804};

  ceespu_mem_model #(
    .ADDR_WIDTH(AW), .DEPTH_LOG2(DL), .READ_LATENCY(RL), .TOHOST_ADDR(16'hFFFC)
  ) dut (
    .I_clk(clk), .I_rst_n(rst_n),
    .I_imemAddress(imem_addr), .O_imemData(imem_data), .O_imemValid(imem_valid),
    .I_dmemAddress(dmem_addr), .I_dmemWData(dmem_wdata), .I_dmemE(dmem_e),
    .I_dmemWe(dmem_we), .O_dmemData(dmem_data), .O_dmemValid(dmem_valid),
    .I_loadE(load_e), .I_loadAddr(load_addr), .I_loadData(load_data),
    .O_done(done), .O_doneValue(done_value), .O_oob(oob), .O_cycles(cycles)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drivers: inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst_n === 1'b1) rel_cycles++;
    @(negedge clk);
  endtask

  task automatic idle();
    dmem_e  = 1'b0;
    dmem_we = 4'b0000;
    load_e  = 1'b0;
  endtask

  task automatic preload(input logic [DL-1:0] a, input logic [31:0] d);
    load_e    = 1'b1;
    load_addr = a;
    load_data = d;
    step();
    load_e    = 1'b0;
  endtask

  task automatic dmem_op(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] we);
    dmem_e     = 1'b1;
    dmem_addr  = a;
    dmem_wdata = d;
    dmem_we    = we;
    step();
    idle();
  endtask

  // Scoreboard comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; imem_addr = '0; dmem_addr = '0; dmem_wdata = '0;
    load_addr = '0; load_data = '0;
    idle();
    step(); step();
    chk("rst_imem_data", imem_data, 32'h0);
    chk("rst_imem_valid", {31'h0, imem_valid}, 32'h0);
    chk("rst_dmem_data", dmem_data, 32'h0);
    chk("rst_dmem_valid", {31'h0, dmem_valid}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_done_value", done_value, 32'h0);
    chk("rst_oob", {31'h0, oob}, 32'h0);
    chk("rst_cycles", cycles, 32'h0);

    rst_n = 1'b1;
    rel_cycles = 0;
    preload(10'd0, init_words[0]);
    chk("imem_valid_wait1", {31'h0, imem_valid}, 32'h0);
    preload(10'd1, init_words[1]);
    chk("imem_valid_wait2", {31'h0, imem_valid}, 32'h0);
    preload(10'd2, init_words[2]);
    chk("imem_valid_first", {31'h0, imem_valid}, 32'h1);
    preload(10'd3, init_words[3]);
    preload(10'd5, 32'h11223344);

    // Back-to-back fetches come out three cycles later with no gaps
    for (int s = 0; s < 6; s++) begin
      if (s < 4) begin
        imem_addr = AW'(4 * s);
        exp_q.push_back(init_words[s]);
      end else begin
        imem_addr = '0;
      end
      step();
      if (s >= 2) begin
        exp_w = exp_q.pop_front();
        chk("lat_valid", {31'h0, imem_valid}, 32'h1);
        chk("lat_data", imem_data, exp_w);
      end
    end

    // Byte-enable store, then load it back
    dmem_op(16'd20, 32'hAABBCCDD, 4'b0101);
    chk("store_no_valid", {31'h0, dmem_valid}, 32'h0);
    dmem_op(16'd20, 32'h0, 4'b0000);
    chk("load_wait1", {31'h0, dmem_valid}, 32'h0);
    step();
    chk("load_wait2", {31'h0, dmem_valid}, 32'h0);
    step();
    chk("be_load_valid", {31'h0, dmem_valid}, 32'h1);
    chk("be_load_data", dmem_data, 32'h11BB33DD);
    step();
    chk("load_valid_pulse", {31'h0, dmem_valid}, 32'h0);
    chk("load_data_hold", dmem_data, 32'h11BB33DD);

    // Store and fetch of the same word in one cycle
    imem_addr = 16'd8;
    dmem_op(16'd8, 32'hDEADBEEF, 4'b1111);
    step();
    imem_addr = 16'd0;
    step();
    chk("collision_old", imem_data, 32'h26b5a000);
    step();
    chk("collision_new", imem_data, 32'hDEADBEEF);

    // Preload beats a same-cycle store to the same word
    load_e = 1'b1; load_addr = 10'd2; load_data = 32'h0;
    dmem_op(16'd8, 32'h12345678, 4'b1111);
    imem_addr = 16'd8;
    step();
    imem_addr = 16'd0;
    step(); step();
    chk("preload_wins", imem_data, 32'h0);
    chk("oob_clear", {31'h0, oob}, 32'h0);

    // Out-of-range load and store
    dmem_op(16'h1000, 32'h0, 4'b0000);
    step(); step();
    chk("oob_load_valid", {31'h0, dmem_valid}, 32'h1);
    chk("oob_load_data", dmem_data, 32'h0);
    chk("oob_set", {31'h0, oob}, 32'h1);
    step(); step();
    chk("oob_sticky", {31'h0, oob}, 32'h1);
    dmem_op(16'h1000, 32'hFFFFFFFF, 4'b1111);
    step(); step(); step();
    chk("oob_store_discard", imem_data, 32'h42a04f06);

    // Reset pulse while a load is in flight
    dmem_op(16'd20, 32'h0, 4'b0000);
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dmem_valid", {31'h0, dmem_valid}, 32'h0);
    chk("mid_rst_imem_valid", {31'h0, imem_valid}, 32'h0);
    chk("mid_rst_dmem_data", dmem_data, 32'h0);
    chk("mid_rst_imem_data", imem_data, 32'h0);
    chk("mid_rst_oob", {31'h0, oob}, 32'h0);
    chk("mid_rst_cycles", cycles, 32'h0);
    #2;
    rst_n = 1'b1;
    rel_cycles = 0;
    step();
    chk("flush_dvalid1", {31'h0, dmem_valid}, 32'h0);
    chk("post_rst_ivalid1", {31'h0, imem_valid}, 32'h0);
    step();
    chk("flush_dvalid2", {31'h0, dmem_valid}, 32'h0);
    chk("post_rst_ivalid2", {31'h0, imem_valid}, 32'h0);
    step();
    chk("flush_dvalid3", {31'h0, dmem_valid}, 32'h0);
    chk("post_rst_ivalid3", {31'h0, imem_valid}, 32'h1);
    chk("mem_retained_imem", imem_data, 32'h42a04f06);
    dmem_op(16'd20, 32'h0, 4'b0000);
    step(); step();
    chk("mem_retained_dvalid", {31'h0, dmem_valid}, 32'h1);
    chk("mem_retained_dmem", dmem_data, 32'h11BB33DD);

    // Tohost completion at cycle 57
    while (rel_cycles < 57) step();
    chk("cycles_count", cycles, 32'd57);
    chk("done_low", {31'h0, done}, 32'h0);
    dmem_op(16'hFFFC, 32'h00000001, 4'b1111);
    chk("done_set", {31'h0, done}, 32'h1);
    chk("done_value", done_value, 32'h1);
    chk("cycles_frozen", cycles, 32'd57);
    dmem_op(16'hFFFC, 32'h00000002, 4'b0001);
    step();
    chk("done_value_first_only", done_value, 32'h1);
    chk("cycles_still_frozen", cycles, 32'd57);
    chk("done_sticky", {31'h0, done}, 32'h1);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ceespu_mem_model.md
Name: ceespu_mem_model

Overview:
- Parametrised instruction/data memory responder for the ceespu core; replaces hand-fed I_imemData/I_dmemData stimulus in core benches.
- Provides word storage with byte-enable writes, configurable fixed read latency (fully pipelined), a bench preload port, a "tohost" completion detector, an out-of-range fault flag and a cycle counter.
- Sits between the ceespu instance and the bench. It is synthesizable, so it can also be used as on-chip RAM.

Parameters:
- ADDR_WIDTH, 16: byte-address width of the imem/dmem ports.
- DEPTH_LOG2, 10: log2 of the number of 32-bit words stored.
- READ_LATENCY, 1: cycles from address sample to data out; legal range 1..4.
- TOHOST_ADDR, 16'hFFFC: byte address whose store signals test completion.

Ports:
- I_clk  in  1  clock; all state changes on rising edge.
- I_rst_n  in  1  asynchronous, active-low reset.
- I_imemAddress  in  ADDR_WIDTH  instruction byte address; a read is issued every cycle.
- O_imemData  out  32  instruction read data.
- O_imemValid  out  1  O_imemData corresponds to the address sampled READ_LATENCY cycles earlier.
- I_dmemAddress  in  ADDR_WIDTH  data byte address.
- I_dmemWData  in  32  store data.
- I_dmemE  in  1  data access enable.
- I_dmemWe  in  4  byte write enables; bit n covers bits [8n+7:8n].
- O_dmemData  out  32  load data.
- O_dmemValid  out  1  load data valid.
- I_loadE  in  1  bench preload write strobe.
- I_loadAddr  in  DEPTH_LOG2  preload word index.
- I_loadData  in  32  preload word.
- O_done  out  1  sticky; a store to TOHOST_ADDR has occurred.
- O_doneValue  out  32  I_dmemWData captured at the tohost store.
- O_oob  out  1  sticky; an access was out of range.
- O_cycles  out  32  cycles since reset release.

Behaviour:
- Reset (I_rst_n low, asynchronous): the following outputs and pipeline stages are 0: O_imemData, O_imemValid, O_dmemData, O_dmemValid, O_done, O_doneValue, O_oob, O_cycles. Memory array contents are not reset and are retained across reset.
- Word index is address[DEPTH_LOG2+1:2]; address[1:0] is ignored.
- An address is out of range when address[ADDR_WIDTH-1:DEPTH_LOG2+2] != 0, except TOHOST_ADDR, which is never out of range.
- Instruction read:
  - The address is sampled every cycle.
  - Data appears exactly READ_LATENCY cycles later with O_imemValid=1.
  - Fully pipelined: one result per cycle, no bubbles.
  - O_imemValid is 0 for the first READ_LATENCY cycles after reset release.
  - An out-of-range address returns 0 with valid=1 and sets O_oob.
- Data load: I_dmemE=1 and I_dmemWe=0. Data appears READ_LATENCY cycles later with O_dmemValid=1. O_dmemValid=0 in all other cycles, and O_dmemData holds its last value.
- Data store: I_dmemE=1 and I_dmemWe!=0. Only the enabled bytes are written, at the rising edge. No O_dmemValid is produced. An out-of-range store is discarded and sets O_oob.
- Read/write collision: an imem read or dmem load to the same word as a same-cycle store returns the pre-store contents (read-before-write). The new value is visible to reads issued from the next cycle.
- Preload: I_loadE writes the full word at I_loadAddr on the edge.
  - If I_loadE and a dmem store target the same word in the same cycle, the preload wins entirely.
  - Preload is legal at any time outside reset.
- Tohost store: I_dmemE=1, I_dmemWe!=0 and address==TOHOST_ADDR.
  - The array is not written.
  - The next cycle, O_done=1 and O_doneValue=I_dmemWData (full word, regardless of I_dmemWe).
  - Only the first tohost store is captured; later ones are ignored until reset.
- O_cycles: increments every cycle after reset release. It stops incrementing from the cycle O_done rises (it holds the count at the tohost store edge) and saturates at 32'hFFFFFFFF.
- Reset mid-operation: all in-flight reads are discarded (valids go to 0 immediately, asynchronously). The first valid after release follows the READ_LATENCY rule.
- READ_LATENCY outside 1..4 is an elaboration error.

Test Plan:
- Latency: READ_LATENCY=3; preload words 0..3 with 32'h42a04f06, 32'h4280fffe, 32'h26b5a000, 32'hd012a804; drive I_imemAddress 0,4,8,12 on consecutive cycles → O_imemValid=1 three cycles after each address, with the four words in order and no gaps.
- Byte enables: preload word 5 = 32'h11223344; store 32'hAABBCCDD to address 20 with We=4'b0101; then load address 20 → O_dmemData=32'h11BB33DD after READ_LATENCY cycles.
- Collision: in one cycle, store 32'hDEADBEEF to address 8 and fetch imem address 8; fetch address 8 again the next cycle → first fetch returns 32'h26b5a000, second returns 32'hDEADBEEF. A same-cycle preload of word 2 = 32'h0 plus a store to address 8 → word 2 reads 0.
- Tohost: after 57 cycles, store 32'h00000001 to 16'hFFFC → O_done=1 the next cycle, O_doneValue=1, O_cycles frozen at 57. A second store of 32'h2 leaves O_doneValue=1.
- Out of range: DEPTH_LOG2=10; load address 16'h1000 → O_dmemData=0, O_oob=1 and held. A store to 16'h1000 → word 0 is unchanged.
- Mid-read reset: issue a load, then pulse I_rst_n low for 3 ns before data returns → O_dmemValid never asserts for that load, all outputs read 0, and preloaded memory contents are intact on the next read.
